regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_sb.sv | 43 ++++
 rtl/regfile_mp.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sequencer states and
// the address-width helper used to size ports from the register count.
package regfile_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int addr_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write port, issue port and ready.
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = regfile_pkg::addr_width(NREG);

   logic [NRD*AW-1:0]   rs;
   logic [NRD*XLEN-1:0] rv;
   logic [NRD-1:0]      rs_busy;
   logic                we;
   logic [AW-1:0]       rd;
   logic [XLEN-1:0]     indata;
   logic                iss_vld;
   logic [AW-1:0]       iss_rd;
   logic                ready;

   modport master (
      output rs, we, rd, indata, iss_vld, iss_rd,
      input  rv, rs_busy, ready
   );

   modport slave (
      input  rs, we, rd, indata, iss_vld, iss_rd,
      output rv, rs_busy, ready
   );
endinterface

// File: rtl/regfile_sb.sv
// Pending-producer scoreboard: one busy bit per register, set on issue,
// cleared on write-back, with issue winning when both hit the same register.
module regfile_sb #(
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              iss_vld,
   input  logic [AW-1:0]     iss_rd,
   input  logic              we,
   input  logic [AW-1:0]     rd,
   input  logic [NRD*AW-1:0] rs,
   output logic [NRD-1:0]    rs_busy
);
   logic [NREG-1:0] busy_q, busy_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < NREG; r++) begin
         if (en && we && rd == AW'(r))          busy_d[r] = 1'b0;
         if (en && iss_vld && iss_rd == AW'(r)) busy_d[r] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   // A write landing this cycle resolves the hazard for the reader already.
   always_comb begin
      rs_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         rs_busy[p] = en && busy_q[rs[p*AW +: AW]] && !(we && rd == rs[p*AW +: AW]);
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with self-clearing init sequence, zero-latency
// bypassed reads, and a pending-producer scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int AW = addr_width(NREG);

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] mem [NREG];
   logic            run;
   logic            mem_we;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdata;
   logic [NRD*XLEN-1:0] rv_flat;

   assign bus.ready = (state_q == ST_RUN);
   assign run       = bus.ready && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // INIT sweeps the array with zeros; RUN takes architectural writes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      waddr   = bus.rd;
      wdata   = bus.indata;
      case (state_q)
         ST_INIT: begin
            mem_we = !reset;
            waddr  = cnt_q;
            wdata  = '0;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            mem_we = !reset && bus.we && (bus.rd != '0);
         end
      endcase
   end

   // NOTE: the array has no reset so it maps to distributed RAM; INIT clears it instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem[waddr] <= wdata;
   end

   always_comb begin
      rv_flat = '0;
      for (int p = 0; p < NRD; p++) begin
         if (run && bus.rs[p*AW +: AW] != '0) begin
            if (bus.we && bus.rd == bus.rs[p*AW +: AW])
               rv_flat[p*XLEN +: XLEN] = bus.indata;
            else
               rv_flat[p*XLEN +: XLEN] = mem[bus.rs[p*AW +: AW]];
         end
      end
   end

   assign bus.rv = rv_flat;

   regfile_sb #(
      .NREG (NREG),
      .NRD  (NRD),
      .AW   (AW)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .en      (run),
      .iss_vld (bus.iss_vld),
      .iss_rd  (bus.iss_rd),
      .we      (bus.we),
      .rd      (bus.rd),
      .rs      (bus.rs),
      .rs_busy (bus.rs_busy)
   );
endmodule
